// File: rtl/bram_stream_reader_pkg.sv
// Shared types and helpers for the BRAM stream reader.
// Imported by the reader top and its FIFO.
package bram_stream_reader_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} rd_state_e;

    // Slots needed to keep one beat per clock: RAM latency,
    // one capture cycle and one registered output beat.
    function automatic int fifo_depth(input int read_latency);
        return read_latency + 2;
    endfunction

endpackage

// File: rtl/bram_reader_fifo.sv
// Small shift-style FIFO: the head is always entry 0,
// so the stream outputs come straight from a register.
module bram_reader_fifo
    import bram_stream_reader_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] ent [DEPTH];
    logic [WIDTH-1:0] nxt [DEPTH];
    logic [CW-1:0]    wr_idx;

    // A push lands one slot lower when the head leaves in the same cycle.
    assign wr_idx = pop ? count - CW'(1) : count;
    assign head   = ent[0];
    assign empty  = (count == '0);

    // Next contents: shift on pop, then drop the new word in place.
    always_comb begin
        nxt = ent;
        if (pop) begin
            for (int i = 0; i < DEPTH - 1; i++) begin
                nxt[i] = ent[i+1];
            end
        end
        if (push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == CW'(i)) begin
                    nxt[i] = din;
                end
            end
        end
    end

    // Storage and occupancy registers.
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                ent[i] <= '0;
            end
            count <= '0;
        end else begin
            ent <= nxt;
            unique case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/bram_stream_reader.sv
// Burst read engine: issues pipelined RAM reads under credit
// control and replays the words as a valid/ready stream.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int DSIZE = 32,
    parameter int RAM_DEPTH = 1024,
    parameter int READ_LATENCY = 2,
    localparam int ASIZE = $clog2(RAM_DEPTH)
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [ASIZE-1:0] cmd_addr,
    input  logic [ASIZE-1:0] cmd_len,
    output logic             ram_en,
    output logic [ASIZE-1:0] ram_addr,
    output logic             ram_regce,
    output logic             ram_rst,
    input  logic [DSIZE-1:0] ram_dout,
    output logic             axis_tvalid,
    input  logic             axis_tready,
    output logic [DSIZE-1:0] axis_tdata,
    output logic             axis_tlast,
    output logic             busy
);

    localparam int FIFO_DEPTH = fifo_depth(READ_LATENCY);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    if (READ_LATENCY != 1 && READ_LATENCY != 2) begin : g_bad_latency
        $fatal(1, "bram_stream_reader: READ_LATENCY must be 1 or 2");
    end

    rd_state_e state, nxt_state;

    logic [ASIZE-1:0]        rd_addr;
    logic [ASIZE-1:0]        remain;
    logic [CW-1:0]           inflight;
    logic [CW-1:0]           fifo_count;
    logic [CW:0]             occ;
    logic                    credit_ok;
    logic                    issue;
    logic                    push;
    logic                    pop;
    logic                    fifo_empty;
    logic [READ_LATENCY-1:0] tag_v;
    logic [READ_LATENCY-1:0] tag_l;
    logic [DSIZE:0]          head;

    // Credit counts only registered state, so tready never
    // reaches the RAM enable combinationally.
    assign occ       = {1'b0, inflight} + {1'b0, fifo_count};
    assign credit_ok = occ < (CW+1)'(FIFO_DEPTH);

    assign push        = tag_v[READ_LATENCY-1];
    assign axis_tvalid = !fifo_empty;
    assign pop         = axis_tvalid && axis_tready;
    assign axis_tdata  = head[DSIZE-1:0];
    assign axis_tlast  = head[DSIZE];

    assign ram_en    = issue;
    assign ram_addr  = rd_addr;
    assign ram_regce = 1'b1;
    assign ram_rst   = rst;
    assign busy      = (state != IDLE);

    // State register.
    always_ff @(posedge clock) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    // Next state, handshake and read issue.
    always_comb begin
        nxt_state = state;
        cmd_ready = 1'b0;
        issue     = 1'b0;
        unique case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    nxt_state = ISSUE;
                end
            end
            ISSUE: begin
                issue = credit_ok;
                if (credit_ok && remain == '0) begin
                    nxt_state = DRAIN;
                end
            end
            DRAIN: begin
                // Leave as the final beat is taken so busy drops next cycle.
                if (inflight == '0 &&
                    (fifo_empty || (fifo_count == CW'(1) && pop))) begin
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    // Burst address and remaining-beat counter; the address wraps
    // at RAM_DEPTH, which need not be a power of two.
    always_ff @(posedge clock) begin
        if (rst) begin
            rd_addr <= '0;
            remain  <= '0;
        end else if (state == IDLE && cmd_valid) begin
            rd_addr <= cmd_addr;
            remain  <= cmd_len;
        end else if (issue) begin
            rd_addr <= (rd_addr == ASIZE'(RAM_DEPTH - 1)) ?
                       '0 : rd_addr + ASIZE'(1);
            remain  <= remain - ASIZE'(1);
        end
    end

    // Tag pipeline tracking which RAM output cycles carry our data.
    always_ff @(posedge clock) begin
        if (rst) begin
            tag_v <= '0;
            tag_l <= '0;
        end else begin
            tag_v[0] <= issue;
            tag_l[0] <= issue && (remain == '0);
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_v[i] <= tag_v[i-1];
                tag_l[i] <= tag_l[i-1];
            end
        end
    end

    // Reads issued but not yet captured into the FIFO.
    always_ff @(posedge clock) begin
        if (rst) begin
            inflight <= '0;
        end else begin
            unique case ({issue, push})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    bram_reader_fifo #(
        .WIDTH (DSIZE + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock (clock),
        .rst   (rst),
        .push  (push),
        .din   ({tag_l[READ_LATENCY-1], ram_dout}),
        .pop   (pop),
        .head  (head),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Bench for bram_stream_reader: instance a is RL=2 with a 1000-deep RAM,
// instance b is RL=1 with a 1024-deep RAM; both read a shared pattern RAM.
module tb_bram_stream_reader;

    localparam int DW = 32;
    localparam int AW = 10;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic                   rst;
    logic                   tready;
    logic [AW-1:0]          caddr, clen;
    logic [1:0]             cvalid, cready, ren, regce, rrst;
    logic [1:0]             tvalid, tlast, busy;
    logic [1:0][AW-1:0]     raddr;
    logic [1:0][DW-1:0]     rdout, tdata;
    logic [DW-1:0]          mem [1024];
    logic [DW-1:0]          q1a, q2a, q1b;

    bram_stream_reader #(.DSIZE(DW), .RAM_DEPTH(1000), .READ_LATENCY(2)) dut_a (
        .clock(clock), .rst(rst),
        .cmd_valid(cvalid[0]), .cmd_ready(cready[0]),
        .cmd_addr(caddr), .cmd_len(clen),
        .ram_en(ren[0]), .ram_addr(raddr[0]), .ram_regce(regce[0]),
        .ram_rst(rrst[0]), .ram_dout(rdout[0]),
        .axis_tvalid(tvalid[0]), .axis_tready(tready),
        .axis_tdata(tdata[0]), .axis_tlast(tlast[0]), .busy(busy[0])
    );

    bram_stream_reader #(.DSIZE(DW), .RAM_DEPTH(1024), .READ_LATENCY(1)) dut_b (
        .clock(clock), .rst(rst),
        .cmd_valid(cvalid[1]), .cmd_ready(cready[1]),
        .cmd_addr(caddr), .cmd_len(clen),
        .ram_en(ren[1]), .ram_addr(raddr[1]), .ram_regce(regce[1]),
        .ram_rst(rrst[1]), .ram_dout(rdout[1]),
        .axis_tvalid(tvalid[1]), .axis_tready(tready),
        .axis_tdata(tdata[1]), .axis_tlast(tlast[1]), .busy(busy[1])
    );

    // RAM read ports: HIGH_PERFORMANCE (two regs) and LOW_LATENCY (one reg).
    always @(posedge clock) begin
        if (ren[0]) q1a <= mem[raddr[0]];
        if (rrst[0]) q2a <= '0;
        else if (regce[0]) q2a <= q1a;
        if (ren[1]) q1b <= mem[raddr[1]];
    end
    assign rdout[0] = q2a;
    assign rdout[1] = q1b;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic [32:0]   acc [2][256];
    logic [AW-1:0] iss [2][256];
    int acc_n [2];
    int iss_n [2];
    int first_cyc [2];
    int last_cyc [2];
    int hs_cyc [2];
    int hs_n [2];
    int max_out [2];
    int stab_err [2];
    int gate_err [2];
    logic        prev_hold [2];
    logic [32:0] prev_word [2];

    // Sampling monitor, away from the active edge.
    always @(negedge clock) begin
        for (int k = 0; k < 2; k++) begin
            if (busy[k] && cready[k]) gate_err[k] <= gate_err[k] + 1;
            if (rst) begin
                acc_n[k] <= 0;
                iss_n[k] <= 0;
                first_cyc[k] <= -1;
                prev_hold[k] <= 1'b0;
            end else begin
                if (cvalid[k] && cready[k]) begin
                    hs_cyc[k] <= cyc;
                    hs_n[k] <= hs_n[k] + 1;
                    first_cyc[k] <= -1;
                end else if (tvalid[k] && first_cyc[k] < 0) begin
                    first_cyc[k] <= cyc;
                end
                if (tvalid[k] && tready) begin
                    if (acc_n[k] < 256) acc[k][acc_n[k]] <= {tlast[k], tdata[k]};
                    acc_n[k] <= acc_n[k] + 1;
                    last_cyc[k] <= cyc;
                end
                if (ren[k]) begin
                    if (iss_n[k] < 256) iss[k][iss_n[k]] <= raddr[k];
                    iss_n[k] <= iss_n[k] + 1;
                end
                if (iss_n[k] - acc_n[k] > max_out[k])
                    max_out[k] <= iss_n[k] - acc_n[k];
                if (prev_hold[k] &&
                    (!tvalid[k] || {tlast[k], tdata[k]} != prev_word[k]))
                    stab_err[k] <= stab_err[k] + 1;
                prev_hold[k] <= tvalid[k] && !tready;
                prev_word[k] <= {tlast[k], tdata[k]};
            end
        end
    end

    // Sink: 0 = hold low, 1 = always ready, 2 = random 50%.
    int tr_mode = 1;
    initial begin
        tready = 1'b0;
        forever begin
            @(posedge clock);
            #1;
            if (tr_mode == 2) tready = 1'($urandom_range(0, 1));
            else tready = (tr_mode == 1);
        end
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic send_cmd(input int k, input int addr, input int len,
                            output int c, output int ba, output int bi);
        int w;
        @(posedge clock);
        #2;
        cvalid[k] = 1'b1;
        caddr = AW'(addr);
        clen = AW'(len);
        c = -1;
        ba = 0;
        bi = 0;
        w = 0;
        while (c < 0 && w < 50) begin
            @(negedge clock);
            if (cready[k]) begin
                c = cyc;
                ba = acc_n[k];
                bi = iss_n[k];
            end
            w++;
        end
        @(posedge clock);
        #2;
        cvalid[k] = 1'b0;
        check("cmd_accept", 64'(c >= 0), 64'd1);
    endtask

    typedef struct {
        int          k;
        int          addr;
        int          len;
        bit          stall;
        logic [31:0] w_first;
        logic [31:0] w_last;
    } vec_t;

    task automatic run_vec(input int idx, input vec_t v);
        int c, ba, bi, n, lat, dep, w, derr, aerr;
        logic [32:0] ew;
        string t;
        t = $sformatf("v%0d", idx);
        n = v.len + 1;
        lat = (v.k == 0) ? 2 : 1;
        dep = (v.k == 0) ? 1000 : 1024;
        tr_mode = v.stall ? 2 : 1;
        send_cmd(v.k, v.addr, v.len, c, ba, bi);
        w = 0;
        while (acc_n[v.k] - ba < n && w < 400) begin
            @(posedge clock);
            w++;
        end
        @(negedge clock);
        check({t, "_busy_fall"}, {62'd0, busy[v.k], cready[v.k]}, 64'd1);
        check({t, "_beats"}, 64'(acc_n[v.k] - ba), 64'(n));
        check({t, "_reads"}, 64'(iss_n[v.k] - bi), 64'(n));
        check({t, "_first_word"}, 64'(acc[v.k][ba]), {31'd0, n == 1, v.w_first});
        check({t, "_last_word"}, 64'(acc[v.k][ba+n-1]), {31'd1, v.w_last});
        derr = 0;
        aerr = 0;
        for (int i = 0; i < n; i++) begin
            ew = {i == n - 1, 32'hA5A5_0000 | 32'((v.addr + i) % dep)};
            if (acc[v.k][ba+i] !== ew) derr++;
            if (iss[v.k][bi+i] !== AW'((v.addr + i) % dep)) aerr++;
        end
        check({t, "_data_errs"}, 64'(derr), 64'd0);
        check({t, "_addr_errs"}, 64'(aerr), 64'd0);
        check({t, "_first_valid"}, 64'(first_cyc[v.k] - c), 64'(lat + 2));
        if (!v.stall)
            check({t, "_last_cycle"}, 64'(last_cyc[v.k] - c), 64'(lat + 1 + n));
    endtask

    vec_t vecs [7];

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c, ba, bi, w, a0, h0, lasts;
        vec_t v;
        vecs[0] = '{0, 5,    0,  1'b0, 32'hA5A5_0005, 32'hA5A5_0005};
        vecs[1] = '{0, 0,    15, 1'b0, 32'hA5A5_0000, 32'hA5A5_000F};
        vecs[2] = '{1, 0,    15, 1'b0, 32'hA5A5_0000, 32'hA5A5_000F};
        vecs[3] = '{0, 0,    15, 1'b1, 32'hA5A5_0000, 32'hA5A5_000F};
        vecs[4] = '{1, 0,    15, 1'b1, 32'hA5A5_0000, 32'hA5A5_000F};
        vecs[5] = '{0, 998,  3,  1'b0, 32'hA5A5_03E6, 32'hA5A5_0001};
        vecs[6] = '{1, 1022, 3,  1'b0, 32'hA5A5_03FE, 32'hA5A5_0001};
        for (int i = 0; i < 1024; i++) mem[i] = 32'hA5A5_0000 | 32'(i);

        rst = 1'b1;
        cvalid = '0;
        caddr = '0;
        clen = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ctrl", {50'd0, cready, ren, tvalid, tlast, busy, regce, rrst},
              {50'd0, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00, 2'b11, 2'b11});
        check("rst_addr", 64'(raddr), 64'd0);
        check("rst_data", 64'(tdata), 64'd0);
        @(posedge clock);
        #2;
        rst = 1'b0;
        @(negedge clock);
        check("ram_rst_low", 64'(rrst), 64'd0);

        for (int i = 0; i < 7; i++) run_vec(i, vecs[i]);

        // Reset after three accepted beats of a ten-beat burst.
        tr_mode = 1;
        send_cmd(0, 40, 9, c, ba, bi);
        w = 0;
        while (acc_n[0] - ba < 3 && w < 100) begin
            @(posedge clock);
            w++;
        end
        #2;
        rst = 1'b1;
        tr_mode = 0;
        tready = 1'b0;
        lasts = 0;
        for (int i = 0; i < 3; i++) if (acc[0][ba+i][32]) lasts++;
        check("mid_pre_beats", 64'(acc_n[0] - ba), 64'd3);
        check("mid_pre_last", 64'(lasts), 64'd0);
        @(posedge clock);
        #2;
        rst = 1'b0;
        tr_mode = 1;
        @(negedge clock);
        check("mid_after_rst", {61'd0, tvalid[0], busy[0], cready[0]}, 64'd1);
        repeat (8) @(negedge clock);
        check("mid_quiet", 64'(acc_n[0]), 64'd0);
        v = '{0, 20, 1, 1'b0, 32'hA5A5_0014, 32'hA5A5_0015};
        run_vec(7, v);

        // Command held valid across a burst.
        tr_mode = 1;
        a0 = acc_n[0];
        h0 = hs_n[0];
        @(posedge clock);
        #2;
        cvalid[0] = 1'b1;
        caddr = AW'(100);
        clen = AW'(3);
        w = 0;
        while (hs_n[0] - h0 < 2 && w < 200) begin
            @(posedge clock);
            w++;
        end
        #2;
        cvalid[0] = 1'b0;
        check("gate_two_cmds", 64'(hs_n[0] - h0), 64'd2);
        check("gate_second_cycle", 64'(hs_cyc[0] - last_cyc[0]), 64'd1);
        w = 0;
        while (busy[0] && w < 200) begin
            @(negedge clock);
            w++;
        end
        check("gate_beats", 64'(acc_n[0] - a0), 64'd8);

        check("max_out_a", 64'(max_out[0] <= 4), 64'd1);
        check("max_out_b", 64'(max_out[1] <= 3), 64'd1);
        check("hold_stable", 64'(stab_err[0] + stab_err[1]), 64'd0);
        check("cmd_gating", 64'(gate_err[0] + gate_err[1]), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
